dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two masters: port 0 = core load/store unit, port 1 = secondary master (UART loader / DMA).
- Sits between the masters and the data memory. Drives its addr/wdata/wr_en/rd_en/func3 inputs and samples its combinational r_data.
- Does round-robin arbitration with optional locked bursts, bounded by MAX_BURST.
- Does address-range checking and reports an error for accesses outside the DMEM region.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_rr_pick.sv | 17 +
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t      : arbiter FSM states
//   DMEM_REGION_DEF  : default addr[31:28] value that selects data memory
//   LB..SW           : func3 access-size codes forwarded to the memory
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    localparam logic [3:0] DMEM_REGION_DEF = 4'h0;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// dmem_arb_rr_pick: combinational two-way round-robin picker.
//   req[1:0] : request vector
//   rr_last  : port that took the most recent beat
//   winner   : selected port (valid when any=1)
//   any      : at least one request present
module dmem_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       winner,
    output logic       any
);

    assign any    = |req;
    // On a tie the port that did not go last wins.
    assign winner = (&req) ? ~rr_last : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between two masters with
// round-robin arbitration, bounded locked bursts and DMEM region checking.
//   clk, rst_n            : clock, asynchronous active-low reset
//   mN_req/we/lock/addr/wdata/func3 : master N request (held until mN_ack)
//   mN_ack/err            : beat issued / beat rejected as out-of-region
//   mN_rdata/rvalid       : registered load data, valid one cycle after ack
//   mem_*                 : data memory interface (mem_rdata combinational)
//   contention_cnt        : cycles with a waiting request; built only when
//                           DMEM_ARB_PERF_CNT_EN is defined, otherwise 0
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter int         MAX_BURST   = 4,
    parameter logic [3:0] DMEM_REGION = DMEM_REGION_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_func3,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_func3,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       contention_cnt
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    arb_state_t        state, state_nx;
    logic              rr_last, rr_nx;
    logic [CW-1:0]     beat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        func3_q;
    logic              winner, any;

    wire               owner     = (state == OWN1);
    wire               o_req     = owner ? m1_req   : m0_req;
    wire               o_we      = owner ? m1_we    : m0_we;
    wire               o_lock    = owner ? m1_lock  : m0_lock;
    wire [ADDR_W-1:0]  o_addr    = owner ? m1_addr  : m0_addr;
    wire [DATA_W-1:0]  o_wdata   = owner ? m1_wdata : m0_wdata;
    wire [2:0]         o_func3   = owner ? m1_func3 : m0_func3;
    wire               other_req = owner ? m0_req   : m1_req;
    wire               beat      = (state != IDLE) && o_req;
    wire               in_region = (o_addr[ADDR_W-1 -: 4] == DMEM_REGION);
    wire               stay      = !other_req || (o_lock && beat_cnt < BURST_LAST);

    dmem_arb_rr_pick u_pick (
        .req    ({m1_req, m0_req}),
        .rr_last(rr_last),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        state_nx = state;
        rr_nx    = rr_last;
        if (state == IDLE) begin
            state_nx = any ? (winner ? OWN1 : OWN0) : IDLE;
        end else if (beat) begin
            rr_nx    = owner;
            state_nx = stay ? state : (owner ? OWN0 : OWN1);
        end else begin
            // Owner dropped its request: hand over immediately or go idle.
            state_nx = other_req ? (owner ? OWN0 : OWN1) : IDLE;
        end
    end

    assign m0_ack    = beat & ~owner;
    assign m1_ack    = beat & owner;
    assign m0_err    = m0_ack & ~in_region;
    assign m1_err    = m1_ack & ~in_region;
    assign mem_wr_en = beat & in_region & o_we;
    assign mem_rd_en = beat & in_region & ~o_we;
    assign mem_addr  = beat ? o_addr  : addr_q;
    assign mem_wdata = beat ? o_wdata : wdata_q;
    assign mem_func3 = beat ? o_func3 : func3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            beat_cnt  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            func3_q   <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_last   <= rr_nx;
            // Saturates at the last allowed burst beat; any owner change restarts it.
            beat_cnt  <= (state_nx != state) ? '0 :
                         (beat && beat_cnt != BURST_LAST) ? beat_cnt + 1'b1 : beat_cnt;
            m0_rvalid <= mem_rd_en & ~owner;
            m1_rvalid <= mem_rd_en & owner;
            if (mem_rd_en && !owner) m0_rdata <= mem_rdata;
            if (mem_rd_en && owner)  m1_rdata <= mem_rdata;
            if (beat) begin
                addr_q  <= o_addr;
                wdata_q <= o_wdata;
                func3_q <= o_func3;
            end
        end
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [15:0] cnt;
    wire         waiting = (m0_req & ~m0_ack) | (m1_req & ~m1_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (waiting && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end

    assign contention_cnt = cnt;
`else
    assign contention_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter; directed scenarios
// plus randomized traffic checked against a transaction-level model.
module tb_dmem_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req, we, lock;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [2:0]  f3 [2];

    logic        m0_ack, m0_err, m0_rvalid, m1_ack, m1_err, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_func3;
    logic        mem_wr_en, mem_rd_en;
    logic [15:0] contention_cnt;

    logic [31:0] tbmem [16];
    logic [31:0] ref_mem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = tbmem[mem_addr[5:2]];
    always @(posedge clk) if (mem_wr_en) tbmem[mem_addr[5:2]] <= mem_wdata;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]), .m0_addr(addr[0]),
        .m0_wdata(wdata[0]), .m0_func3(f3[0]), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]), .m1_addr(addr[1]),
        .m1_wdata(wdata[1]), .m1_func3(f3[1]), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .contention_cnt(contention_cnt)
    );

    task automatic idle_inputs();
        req = 2'b00; we = 2'b00; lock = 2'b00;
        for (int p = 0; p < 2; p++) begin
            addr[p] = 32'h0; wdata[p] = 32'h0; f3[p] = 3'b010;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b11;
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack, m0_err, m1_err, m0_rvalid, m1_rvalid, mem_wr_en, mem_rd_en} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000000",
                     {m0_ack, m1_ack, m0_err, m1_err, m0_rvalid, m1_rvalid, mem_wr_en, mem_rd_en});
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h %h want 0", m0_rdata, m1_rdata);
        end
        checks++;
        if (contention_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", contention_cnt);
        end
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_single_load();
        do_reset();
        tbmem[1] = 32'hDEAD_BEEF;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_0004; f3[0] = 3'b010;
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL load_early_ack got %b want 0", m0_ack);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({m0_ack, m0_err, mem_rd_en, mem_wr_en, m0_rvalid} !== 5'b10100) begin
            errors++;
            $display("FAIL load_ack got %b want 10100", {m0_ack, m0_err, mem_rd_en, mem_wr_en, m0_rvalid});
        end
        checks++;
        if (mem_addr !== 32'h4 || mem_func3 !== 3'b010) begin
            errors++;
            $display("FAIL load_mem_addr got %h/%0d want 4/2", mem_addr, mem_func3);
        end
        next_cycle();
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_rdata got %b/%h want 1/deadbeef", m0_rvalid, m0_rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_rvalid_pulse got %b/%h want 0/deadbeef", m0_rvalid, m0_rdata);
        end
        next_cycle();
    endtask

    task automatic test_alternate();
        int k = 0;
        do_reset();
        req = 2'b11; we = 2'b11;
        addr[0] = 32'h10; addr[1] = 32'h20;
        wdata[0] = 32'h11; wdata[1] = 32'h22;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                checks++;
                if ((m0_ack && m1_ack) || m1_ack !== k[0]) begin
                    errors++;
                    $display("FAIL alt_order ack#%0d got m0=%b m1=%b want port %0d", k, m0_ack, m1_ack, k % 2);
                end
                k++;
            end
            next_cycle();
        end
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (k != 9) begin
            errors++;
            $display("FAIL alt_count got %0d want 9", k);
        end
        checks++;
        if (tbmem[4] !== 32'h11 || tbmem[8] !== 32'h22) begin
            errors++;
            $display("FAIL alt_mem got %h %h want 11 22", tbmem[4], tbmem[8]);
        end
        checks++;
`ifdef DMEM_ARB_PERF_CNT_EN
        if (contention_cnt !== 16'd10) begin
            errors++;
            $display("FAIL alt_contention got %0d want 10", contention_cnt);
        end
`else
        if (contention_cnt !== 16'd0) begin
            errors++;
            $display("FAIL alt_contention got %0d want 0", contention_cnt);
        end
`endif
        next_cycle();
    endtask

    task automatic test_locked_burst();
        int seq[$];
        int want[7] = '{1, 1, 1, 1, 0, 1, 1};
        int n1 = 0;
        do_reset();
        req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'h100;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m0_ack) seq.push_back(0);
            if (m1_ack) begin
                seq.push_back(1);
                n1++;
            end
            next_cycle();
            req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h34;
            wdata[1] = 32'h100 + 32'(n1);
            if (n1 == 6) begin
                req[1] = 1'b0;
                lock[1] = 1'b0;
            end
        end
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (i >= seq.size() || seq[i] != want[i]) begin
                errors++;
                $display("FAIL burst_order beat %0d got %0d want %0d", i, (i < seq.size()) ? seq[i] : -1, want[i]);
            end
        end
        checks++;
        if (n1 != 6 || tbmem[12] !== 32'h105) begin
            errors++;
            $display("FAIL burst_m1 got %0d acks last %h want 6 acks last 105", n1, tbmem[12]);
        end
        next_cycle();
    endtask

    task automatic test_out_of_region();
        do_reset();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h8000_0000;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        checks++;
        if ({m0_ack, m0_err, mem_rd_en, mem_wr_en} !== 4'b1100) begin
            errors++;
            $display("FAIL oor_ack got %b want 1100", {m0_ack, m0_err, mem_rd_en, mem_wr_en});
        end
        next_cycle();
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL oor_rvalid got %b want 0", m0_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        tbmem[15] = 32'h5A5A_5A5A;
        req[0] = 1'b1; lock[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h3C; wdata[0] = 32'h1111_0001;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        wdata[0] = 32'h2222_0002;
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b1 || m0_ack !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got wr=%b ack=%b want 1 1", mem_wr_en, m0_ack);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({m0_ack, m1_ack, m0_err, m1_err, m0_rvalid, m1_rvalid, mem_wr_en, mem_rd_en} !== 8'h00) begin
            errors++;
            $display("FAIL mid_async got %b want 00000000",
                     {m0_ack, m1_ack, m0_err, m1_err, m0_rvalid, m1_rvalid, mem_wr_en, mem_rd_en});
        end
        req = 2'b11; we[1] = 1'b1; addr[1] = 32'h38;
        next_cycle();
        checks++;
        if (tbmem[15] !== 32'h1111_0001) begin
            errors++;
            $display("FAIL mid_nowrite got %h want 11110001", tbmem[15]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle got m0=%b m1=%b want 0 0", m0_ack, m1_ack);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_first got m0=%b m1=%b want 1 0", m0_ack, m1_ack);
        end
        next_cycle();
        idle_inputs();
    endtask

    // Transaction-level reference: who owns the memory, who went last, how many
    // beats the current owner has had, plus the expected registered outputs.
    int          m_own, m_last, m_burst, n_own, n_last, n_burst;
    bit [1:0]    m_rv, n_rv, e_ack, e_err;
    bit          e_wr, e_rd, e_beat;
    logic [31:0] m_rd [2];
    logic [31:0] n_rd [2];
    int unsigned m_cnt, n_cnt;

    task automatic model_eval();
        int o;
        bit inr;
        e_ack = 2'b00; e_err = 2'b00; e_wr = 1'b0; e_rd = 1'b0;
        e_beat = (m_own >= 0) && req[m_own];
        n_rv = 2'b00;
        n_rd = m_rd;
        if (e_beat) begin
            inr = (addr[m_own][31:28] == 4'h0);
            e_ack[m_own] = 1'b1;
            e_err[m_own] = !inr;
            e_wr = inr && we[m_own];
            e_rd = inr && !we[m_own];
            if (e_rd) begin
                n_rv[m_own] = 1'b1;
                n_rd[m_own] = ref_mem[addr[m_own][5:2]];
            end
        end
        if (m_own < 0) begin
            n_own = (req == 2'b00) ? -1 : (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
        end else begin
            o = 1 - m_own;
            if (e_beat) n_own = (req[o] && !(lock[m_own] && m_burst + 1 < MB)) ? o : m_own;
            else        n_own = req[o] ? o : -1;
        end
        n_last  = e_beat ? m_own : m_last;
        n_burst = (n_own != m_own) ? 0 : m_burst + (e_beat ? 1 : 0);
        n_cnt   = (((req[0] && !e_ack[0]) || (req[1] && !e_ack[1])) && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    endtask

    task automatic new_request(input int p);
        req[p]   = 1'b1;
        we[p]    = 1'($urandom);
        lock[p]  = 1'($urandom);
        addr[p]  = ($urandom_range(7) == 0) ? {4'($urandom_range(15, 1)), 28'($urandom)}
                                            : {4'h0, 22'($urandom), 4'($urandom), 2'b00};
        wdata[p] = $urandom;
        f3[p]    = 3'($urandom);
    endtask

    task automatic test_random();
        bit [1:0] got;
        do_reset();
        m_own = -1; m_last = 1; m_burst = 0; m_rv = 2'b00; m_cnt = 0;
        m_rd[0] = 32'h0; m_rd[1] = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = tbmem[i];
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            model_eval();
            got = {m1_ack, m0_ack};
            checks++;
            if ({m1_ack, m0_ack, m1_err, m0_err, mem_wr_en, mem_rd_en} !== {e_ack, e_err, e_wr, e_rd}) begin
                errors++;
                $display("FAIL rnd_ctrl cyc %0d got %b want %b", c,
                         {m1_ack, m0_ack, m1_err, m0_err, mem_wr_en, mem_rd_en}, {e_ack, e_err, e_wr, e_rd});
            end
            if (e_beat) begin
                checks++;
                if (mem_addr !== addr[m_own] || mem_wdata !== wdata[m_own] || mem_func3 !== f3[m_own]) begin
                    errors++;
                    $display("FAIL rnd_mem cyc %0d got %h/%h/%0d want %h/%h/%0d", c, mem_addr, mem_wdata,
                             mem_func3, addr[m_own], wdata[m_own], f3[m_own]);
                end
            end
            checks++;
            if ({m1_rvalid, m0_rvalid} !== m_rv || m0_rdata !== m_rd[0] || m1_rdata !== m_rd[1]) begin
                errors++;
                $display("FAIL rnd_rdata cyc %0d got %b %h %h want %b %h %h", c, {m1_rvalid, m0_rvalid},
                         m0_rdata, m1_rdata, m_rv, m_rd[0], m_rd[1]);
            end
            checks++;
`ifdef DMEM_ARB_PERF_CNT_EN
            if (contention_cnt !== 16'(m_cnt)) begin
`else
            if (contention_cnt !== 16'd0) begin
`endif
                errors++;
                $display("FAIL rnd_contention cyc %0d got %0d", c, contention_cnt);
            end
            @(posedge clk);
            if (e_wr) ref_mem[addr[m_own][5:2]] = wdata[m_own];
            m_own = n_own; m_last = n_last; m_burst = n_burst;
            m_rv = n_rv; m_rd = n_rd; m_cnt = n_cnt;
            #1;
            for (int p = 0; p < 2; p++) begin
                if (got[p] || !req[p]) begin
                    if ($urandom_range(3) != 0) new_request(p);
                    else req[p] = 1'b0;
                end else if ($urandom_range(31) == 0) begin
                    req[p] = 1'b0;
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbmem[i] = 32'hA000_0000 + 32'(i);
        idle_inputs();
        test_reset();
        test_single_load();
        test_alternate();
        test_locked_burst();
        test_out_of_region();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
